// File: rtl/spi_top.sv
// SPI loopback: an SCLK generator, a master FSM and a slave joined by sclk/mosi/miso/cs.
// Frames repeat while req is non-zero; received words and frame progress are exposed as outputs.
module spi_top #(
  parameter int MASTER_FREQ = 100_000_000,
  parameter int SLAVE_FREQ  = 1_800_000,
  parameter int SPI_MODE    = 1,
  parameter int SPI_TRF_BIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [7:0]             wait_duration,
  input  logic [SPI_TRF_BIT-1:0] din_master,
  input  logic [SPI_TRF_BIT-1:0] din_slave,
  output logic [SPI_TRF_BIT-1:0] dout_master,
  output logic [SPI_TRF_BIT-1:0] dout_slave,
  output logic                   done_tx,
  output logic                   done_rx,
  output logic [31:0]            bit_counter,
  output logic [31:0]            sclk_senddata
);
  localparam int   N        = SPI_TRF_BIT;
  localparam int   HALF_RAW = MASTER_FREQ / (2 * SLAVE_FREQ);
  localparam int   HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int   HW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic CPOL     = ((SPI_MODE >> 1) & 1) != 0;
  localparam logic CPHA     = (SPI_MODE & 1) != 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    req_q, req_d;
  logic [7:0]    wait_q, wait_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic [31:0]   period_cnt_q, period_cnt_d;
  logic [N-1:0]  mtx_q, mtx_d;
  logic [N-1:0]  stx_q, stx_d;
  logic [N-1:0]  dout_master_q, dout_master_d;
  logic [N-1:0]  dout_slave_q, dout_slave_d;
  logic          done_tx_q, done_tx_d;
  logic          done_rx_q, done_rx_d;
  logic [31:0]   bit_cnt_q, bit_cnt_d;

  logic sclk, cs, mosi, miso;
  logic toggle, lead_edge, trail_edge, sample_edge, shift_edge, last_edge;
  logic start_frame;

  assign cs   = cs_q;
  assign sclk = cs_q ? CPOL : sclk_q;
  assign mosi = (!cs && req_q[0]) ? mtx_q[N-1] : 1'b0;
  assign miso = (!cs && req_q[1]) ? stx_q[N-1] : 1'b0;

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign toggle      = (state_q == TRANSFER) && (half_cnt_q == HW'(HALF - 1));
  assign lead_edge   = toggle && (sclk == CPOL);
  assign trail_edge  = toggle && (sclk != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? (lead_edge && (period_cnt_q != 32'd0)) : trail_edge;
  assign last_edge   = trail_edge && (period_cnt_q == 32'(N - 1));

  // SCLK generator and master sequencing
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    wait_d       = wait_q;
    wait_cnt_d   = wait_cnt_q;
    half_cnt_d   = half_cnt_q;
    sclk_d       = sclk_q;
    cs_d         = cs_q;
    period_cnt_d = period_cnt_q;
    done_tx_d    = 1'b0;
    done_rx_d    = 1'b0;
    start_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'd0) begin
          req_d      = req;
          wait_d     = wait_duration;
          wait_cnt_d = 8'd0;
          if (wait_duration == 8'd0) start_frame = 1'b1;
          else                       state_d     = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_q == wait_q - 8'd1) start_frame = 1'b1;
        else                             wait_cnt_d  = wait_cnt_q + 8'd1;
      end
      TRANSFER: begin
        if (toggle) begin
          half_cnt_d = '0;
          sclk_d     = ~sclk_q;
        end else begin
          half_cnt_d = half_cnt_q + HW'(1);
        end
        if (trail_edge) period_cnt_d = period_cnt_q + 32'd1;
        if (last_edge) begin
          state_d   = DONE;
          cs_d      = 1'b1;
          sclk_d    = CPOL;
          done_tx_d = req_q[0];
          done_rx_d = req_q[1];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start_frame) begin
      state_d      = TRANSFER;
      cs_d         = 1'b0;
      sclk_d       = CPOL;
      half_cnt_d   = '0;
      period_cnt_d = 32'd0;
    end
  end

  // Master data path: drives mosi, samples miso
  always_comb begin
    mtx_d         = mtx_q;
    dout_master_d = dout_master_q;
    bit_cnt_d     = bit_cnt_q;
    if (start_frame) begin
      mtx_d     = din_master;
      bit_cnt_d = 32'd0;
    end else begin
      if (shift_edge) mtx_d = {mtx_q[N-2:0], 1'b0};
      if (sample_edge) begin
        bit_cnt_d = bit_cnt_q + 32'd1;
        if (req_q[1]) dout_master_d = {dout_master_q[N-2:0], miso};
      end
    end
  end

  // Slave data path: drives miso, samples mosi
  always_comb begin
    stx_d        = stx_q;
    dout_slave_d = dout_slave_q;
    if (start_frame) begin
      stx_d = din_slave;
    end else begin
      if (shift_edge) stx_d = {stx_q[N-2:0], 1'b0};
      if (sample_edge && req_q[0]) dout_slave_d = {dout_slave_q[N-2:0], mosi};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      req_q         <= 2'd0;
      wait_q        <= 8'd0;
      wait_cnt_q    <= 8'd0;
      half_cnt_q    <= '0;
      sclk_q        <= CPOL;
      cs_q          <= 1'b1;
      period_cnt_q  <= 32'd0;
      mtx_q         <= '0;
      stx_q         <= '0;
      dout_master_q <= '0;
      dout_slave_q  <= '0;
      done_tx_q     <= 1'b0;
      done_rx_q     <= 1'b0;
      bit_cnt_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      wait_q        <= wait_d;
      wait_cnt_q    <= wait_cnt_d;
      half_cnt_q    <= half_cnt_d;
      sclk_q        <= sclk_d;
      cs_q          <= cs_d;
      period_cnt_q  <= period_cnt_d;
      mtx_q         <= mtx_d;
      stx_q         <= stx_d;
      dout_master_q <= dout_master_d;
      dout_slave_q  <= dout_slave_d;
      done_tx_q     <= done_tx_d;
      done_rx_q     <= done_rx_d;
      bit_cnt_q     <= bit_cnt_d;
    end
  end

  assign dout_master   = dout_master_q;
  assign dout_slave    = dout_slave_q;
  assign done_tx       = done_tx_q;
  assign done_rx       = done_rx_q;
  assign bit_counter   = bit_cnt_q;
  assign sclk_senddata = period_cnt_q;
endmodule

// File: tb/tb_spi_top.sv
// Bench for spi_top: a cycle-level arithmetic model of frame timing and received data checked every
// cycle, plus directed frames with hand-computed results, random frames and a mid-frame reset.
`timescale 1ns/1ps
module tb_spi_top;
  localparam int N      = 8;
  localparam int HALF   = 100_000_000 / (2 * 1_800_000);
  localparam int CPHA   = 1;
  localparam int FRAME  = 2 * N * HALF;
  localparam int BUDGET = 3000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   req = 2'd0;
  logic [7:0]   wait_duration = 8'd0;
  logic [N-1:0] din_master = '0;
  logic [N-1:0] din_slave = '0;
  logic [N-1:0] dout_master, dout_slave;
  logic         done_tx, done_rx;
  logic [31:0]  bit_counter, sclk_senddata;

  int n_cmp = 0;
  int n_bad = 0;

  spi_top #(
    .MASTER_FREQ(100_000_000),
    .SLAVE_FREQ (1_800_000),
    .SPI_MODE   (1),
    .SPI_TRF_BIT(N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wait_duration(wait_duration),
    .din_master   (din_master),
    .din_slave    (din_slave),
    .dout_master  (dout_master),
    .dout_slave   (dout_slave),
    .done_tx      (done_tx),
    .done_rx      (done_rx),
    .bit_counter  (bit_counter),
    .sclk_senddata(sclk_senddata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a frame requested in an idle cycle c starts at T = c+1+wait and ends (done) at T+2*N*HALF.
  // Sample j lands at T+(2j+1+CPHA)*HALF, SCLK period p completes at T+(2p+2)*HALF.
  int           cyc = 0;
  bit           busy = 1'b0;
  logic [1:0]   fr_req = 2'd0;
  int           t_start = 0;
  int           t_done = 0;
  logic [N-1:0] lat_m = '0, lat_s = '0, base_m = '0, base_s = '0;
  logic [N-1:0] st_m = '0, st_s = '0;
  int           st_bc = 0, st_pc = 0;

  always @(negedge clk) begin
    logic [N-1:0]   exp_m, exp_s;
    logic [2*N-1:0] sh;
    logic           exp_tx, exp_rx;
    int             k, p;
    cyc++;
    if (!rst) begin
      busy  = 1'b0;
      st_m  = '0;
      st_s  = '0;
      st_bc = 0;
      st_pc = 0;
    end else if (!busy && req != 2'd0) begin
      busy    = 1'b1;
      fr_req  = req;
      t_start = cyc + 1 + int'(wait_duration);
      t_done  = t_start + FRAME;
      base_m  = st_m;
      base_s  = st_s;
    end
    if (busy && cyc == t_start - 1) begin
      lat_m = din_master;
      lat_s = din_slave;
    end
    exp_m  = st_m;
    exp_s  = st_s;
    k      = st_bc;
    p      = st_pc;
    exp_tx = 1'b0;
    exp_rx = 1'b0;
    if (busy && cyc >= t_start) begin
      k = 0;
      p = 0;
      for (int j = 0; j < N; j++) begin
        if (cyc >= t_start + (2 * j + 1 + CPHA) * HALF) k++;
        if (cyc >= t_start + (2 * j + 2) * HALF) p++;
      end
      if (fr_req[0]) begin
        sh    = {base_s, lat_m};
        sh    = sh << k;
        exp_s = sh[2*N-1:N];
      end
      if (fr_req[1]) begin
        sh    = {base_m, lat_s};
        sh    = sh << k;
        exp_m = sh[2*N-1:N];
      end
      exp_tx = (cyc == t_done) && fr_req[0];
      exp_rx = (cyc == t_done) && fr_req[1];
      st_m   = exp_m;
      st_s   = exp_s;
      st_bc  = k;
      st_pc  = p;
      if (cyc == t_done) busy = 1'b0;
    end
    chk("dout_master",   32'(dout_master),   32'(exp_m));
    chk("dout_slave",    32'(dout_slave),    32'(exp_s));
    chk("done_tx",       32'(done_tx),       32'(exp_tx));
    chk("done_rx",       32'(done_rx),       32'(exp_rx));
    chk("bit_counter",   bit_counter,        32'(k));
    chk("sclk_senddata", sclk_senddata,      32'(p));
  end

  task automatic wait_done(input int chg_at, output int cycles);
    cycles = 0;
    while (1) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == chg_at) begin
        din_master = N'($urandom);
        din_slave  = N'($urandom);
        req        = 2'($urandom_range(0, 3));
      end
      if (done_tx || done_rx) return;
      if (cycles >= BUDGET) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_wait: no done pulse after %0d cycles, required one", cycles);
        return;
      end
    end
  endtask

  initial begin
    int           cycles;
    logic [N-1:0] prev;

    repeat (3) @(posedge clk); #1;
    chk("rst_dout_master", 32'(dout_master), 32'd0);
    chk("rst_dout_slave",  32'(dout_slave),  32'd0);
    chk("rst_done_tx",     32'(done_tx),     32'd0);
    chk("rst_done_rx",     32'(done_rx),     32'd0);
    chk("rst_bit_counter", bit_counter,      32'd0);
    chk("rst_sclk_cnt",    sclk_senddata,    32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // MOSI-only frame
    din_master = 8'hA5; din_slave = 8'h11; wait_duration = 8'd10; req = 2'd1;
    wait_done(0, cycles);
    req = 2'd0;
    chk("A_latency",     32'(cycles),      32'd443);
    chk("A_done_tx",     32'(done_tx),     32'd1);
    chk("A_done_rx",     32'(done_rx),     32'd0);
    chk("A_dout_slave",  32'(dout_slave),  32'hA5);
    chk("A_dout_master", 32'(dout_master), 32'h00);
    chk("A_bits",        bit_counter,      32'd8);
    chk("A_periods",     sclk_senddata,    32'd8);

    // MISO-only frame
    repeat (3) @(posedge clk); #1;
    din_master = N'($urandom); din_slave = 8'h3C; wait_duration = 8'd0; req = 2'd2;
    wait_done(0, cycles);
    req = 2'd0;
    chk("B_latency",     32'(cycles),      32'd433);
    chk("B_done_tx",     32'(done_tx),     32'd0);
    chk("B_done_rx",     32'(done_rx),     32'd1);
    chk("B_dout_master", 32'(dout_master), 32'h3C);
    chk("B_dout_slave",  32'(dout_slave),  32'hA5);

    // Full duplex frame
    repeat (3) @(posedge clk); #1;
    din_master = 8'h81; din_slave = 8'h7E; wait_duration = 8'd5; req = 2'd3;
    wait_done(0, cycles);
    req = 2'd0;
    chk("C_latency",     32'(cycles),      32'd438);
    chk("C_done_tx",     32'(done_tx),     32'd1);
    chk("C_done_rx",     32'(done_rx),     32'd1);
    chk("C_dout_slave",  32'(dout_slave),  32'h81);
    chk("C_dout_master", 32'(dout_master), 32'h7E);

    // Five back-to-back MOSI frames
    repeat (3) @(posedge clk); #1;
    din_master = N'($urandom); prev = din_master; wait_duration = 8'd10; req = 2'd1;
    for (int i = 0; i < 5; i++) begin
      wait_done(0, cycles);
      chk("D_dout_slave", 32'(dout_slave), 32'(prev));
      if (i > 0) begin
        chk("D_gap",     32'(cycles),         32'd444);
        chk("D_gap_min", 32'(cycles >= 10),   32'd1);
      end
      din_master = N'($urandom);
      prev       = din_master;
    end
    req = 2'd0;

    // Random frames with inputs changing mid-frame
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      din_master    = N'($urandom);
      din_slave     = N'($urandom);
      wait_duration = 8'($urandom_range(0, 20));
      req           = 2'($urandom_range(1, 3));
      wait_done(int'($urandom_range(2, 300)), cycles);
    end
    req = 2'd0;

    // Reset in the middle of a frame
    repeat (3) @(posedge clk); #1;
    din_master = N'($urandom); din_slave = N'($urandom); wait_duration = 8'd3; req = 2'd3;
    repeat (150) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("F_dout_master", 32'(dout_master), 32'd0);
    chk("F_dout_slave",  32'(dout_slave),  32'd0);
    chk("F_done_tx",     32'(done_tx),     32'd0);
    chk("F_done_rx",     32'(done_rx),     32'd0);
    chk("F_bits",        bit_counter,      32'd0);
    chk("F_periods",     sclk_senddata,    32'd0);
    repeat (3) @(posedge clk); #1;
    din_master = 8'h5A; wait_duration = 8'd2; req = 2'd1;
    rst = 1'b1;
    wait_done(0, cycles);
    req = 2'd0;
    chk("G_latency",     32'(cycles),      32'd435);
    chk("G_done_tx",     32'(done_tx),     32'd1);
    chk("G_dout_slave",  32'(dout_slave),  32'h5A);
    chk("G_dout_master", 32'(dout_master), 32'h00);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_top.md
SPI_TOP -- requirements
Module: spi_top

Interface
REQ-001 SHALL have parameter MASTER_FREQ, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter SLAVE_FREQ, default 1_800_000, meaning target SCLK frequency in Hz.
REQ-003 SHALL have parameter SPI_MODE, default 1, meaning SPI mode 0..3 (CPOL = bit1, CPHA = bit0).
REQ-004 SHALL have parameter SPI_TRF_BIT, default 8, meaning frame width in bits.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, 2 bits: 0 idle, 1 master→slave (MOSI), 2 slave→master (MISO), 3 full duplex.
REQ-008 SHALL have port wait_duration, input, 8 bits: idle clk cycles between consecutive frames.
REQ-009 SHALL have port din_master, input, SPI_TRF_BIT bits: master transmit word.
REQ-010 SHALL have port din_slave, input, SPI_TRF_BIT bits: slave transmit word.
REQ-011 SHALL have port dout_master, output, SPI_TRF_BIT bits: master receive shift register.
REQ-012 SHALL have port dout_slave, output, SPI_TRF_BIT bits: slave receive shift register.
REQ-013 SHALL have port done_tx, output, 1 bit: one-clk pulse when a MOSI frame completes.
REQ-014 SHALL have port done_rx, output, 1 bit: one-clk pulse when a MISO frame completes.
REQ-015 SHALL have port bit_counter, output, 32 bits: bits shifted so far in the current frame.
REQ-016 SHALL have port sclk_senddata, output, 32 bits: SCLK periods elapsed in the current frame.

Function
REQ-017 SHALL contain an SCLK generator, a master and a slave, connected internally by sclk, mosi, miso and cs (active low).
REQ-018 SHALL derive the SCLK half-period as HALF = MASTER_FREQ/(2*SLAVE_FREQ) clk cycles, using integer division with a minimum of 1 (27 for the defaults).
REQ-019 SHALL hold SCLK at its CPOL idle level whenever cs is high.
REQ-020 SHALL, in the master, use FSM states IDLE(0) → WAIT(1) → TRANSFER(2) → DONE(3) → IDLE.
REQ-021 SHALL, in IDLE with req≠0, enter WAIT and count wait_duration clk cycles; wait_duration = 0 means go to TRANSFER on the next clk.
REQ-022 SHALL, on entry to TRANSFER, latch din_master and din_slave, assert cs low, and start SCLK.
REQ-023 SHALL transmit data MSB first, SPI_TRF_BIT bits per frame.
REQ-024 SHALL, for mode 1, drive data on the SCLK rising edge and sample it on the falling edge; other modes follow standard CPOL/CPHA rules.
REQ-025 SHALL, for req 1 or 3, shift the slave's sample into dout_slave as {dout_slave[N-2:0], mosi} on each sampling edge.
REQ-026 SHALL, for req 2 or 3, shift the master's sample into dout_master as {dout_master[N-2:0], miso} on each sampling edge.
REQ-027 SHALL not clear dout_master or dout_slave between frames.
REQ-028 SHALL, for req 2, drive mosi to 0 and leave dout_slave unchanged; for req 1, leave dout_master unchanged.
REQ-029 SHALL, after the Nth sampling edge, enter DONE for one clk: raise cs, pulse done_tx if req is 1 or 3, and pulse done_rx if req is 2 or 3 (both pulse in the same cycle for req 3).
REQ-030 SHALL, in DONE, return to IDLE; frames repeat continuously while req≠0.
REQ-031 SHALL sample req only in IDLE; a change of req mid-frame takes effect after the current frame completes.
REQ-032 SHALL reset bit_counter and sclk_senddata to 0 at frame start, increment each per sampled bit and per SCLK period respectively, and hold them until the next frame starts.

Reset
REQ-033 SHALL, while rst=0, asynchronously force: FSMs to IDLE, SCLK to its idle level, cs=1, mosi=0, dout_master=0, dout_slave=0, done_tx=0, done_rx=0, bit_counter=0, sclk_senddata=0.
REQ-034 SHALL abort any frame in progress when reset is asserted, with no done pulse generated.
REQ-035 SHALL resume from IDLE on the first clk after rst rises.

Verification
REQ-036 SHALL pass: req=1, din_master=8'hA5, wait_duration=10 -> one done_tx pulse; dout_slave=8'hA5; done_rx never asserted.
REQ-037 SHALL pass: req=2, din_slave=8'h3C -> one done_rx pulse; dout_master=8'h3C; dout_slave unchanged.
REQ-038 SHALL pass: req=3, din_master=8'h81, din_slave=8'h7E -> done_tx and done_rx pulse in the same cycle; dout_slave=8'h81; dout_master=8'h7E.
REQ-039 SHALL pass: five back-to-back random frames with req=1 -> each dout_slave equals the din_master latched at that frame's start, and frame gaps are at least wait_duration clks.
REQ-040 SHALL pass: assert rst=0 mid-frame -> all outputs return to 0 immediately with no done pulse, and the next frame after release is correct.
REQ-041 SHALL pass: at each SCLK falling edge in mode 1, dout_slave equals the MSB-first prefix of din_master shifted in so far.
